// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op and FSM encodings,
// datapath width and the special-case result constants.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring shift-subtract
// steps on operand magnitudes, then a sign/special-case fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  state_e            state;
  op_e               op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opr;
  logic [4:0]        cnt;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              neg_r;
  logic              div0;
  logic              ovf;

  // Operand preparation at acceptance
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
  end

  // One iteration step. Multiply keeps the multiplier in acc's low half and
  // shifts right; divide keeps the dividend there and shifts left.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] step_acc;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opr : {XLEN{1'b0}})};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, opr};
    rem_ge   = (rem_sh >= {1'b0, opr});
    if (op[2]) begin
      step_acc = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
    end else begin
      step_acc = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Final result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = neg_q ? (~acc + 1'b1) : acc;
    quot = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (op)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div0)     fix_res = DIV0_QUOT;
        else if (ovf) fix_res = INT_MIN;
        else          fix_res = quot;
      end
      // A zero divisor leaves |op_a| as the remainder, which the dividend
      // sign then restores to op_a exactly.
      OP_REM, OP_REMU: fix_res = ovf ? '0 : rem;
      default:         fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_MUL;
      acc    <= '0;
      opr    <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_out <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done   <= 1'b0;
      we_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op    <= op_e'(funct3);
            rd_q  <= rd_in;
            cnt   <= '0;
            busy  <= 1'b1;
            neg_q <= a_neg ^ b_neg;
            if (is_div) begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              opr   <= b_mag;
              neg_r <= a_neg;
              div0  <= (op_b == '0);
              ovf   <= a_signed && (op_a == INT_MIN) && (op_b == '1);
              if (op_b == '0) neg_q <= 1'b0;
            end else begin
              acc   <= {{XLEN{1'b0}}, b_mag};
              opr   <= a_mag;
              neg_r <= 1'b0;
              div0  <= 1'b0;
              ovf   <= 1'b0;
            end
            state <= CALC;
          end
        end
        CALC: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
          if (&cnt) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          rd_out <= rd_q;
          done   <= 1'b1;
          we_out <= (rd_q != '0);
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock, shared with the register file.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  in  32  rs1 value, taken from register-file RD1.
REQ-008 op_b  in  32  rs2 value, taken from register-file RD2.
REQ-009 rd_in  in  5  destination register index.
REQ-010 busy  out  1  high from acceptance until the DONE cycle ends.
REQ-011 done  out  1  one-cycle result-valid pulse.
REQ-012 result  out  32  result; drives register-file WD3.
REQ-013 rd_out  out  5  captured rd_in; drives register-file A3.
REQ-014 we_out  out  1  equals done AND (rd_out != 0); drives register-file WE3.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-016 IDLE: if start=1 at edge k, the block SHALL capture funct3, op_a, op_b and rd_in, clear the 5-bit step counter, and enter CALC.
REQ-017 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on the operand magnitudes, for exactly 32 cycles, then enter FIX at edge k+32.
REQ-018 FIX SHALL apply sign correction and special-case selection and register result, then enter DONE at edge k+33.
REQ-019 DONE SHALL assert done=1 for one cycle, then return to IDLE at edge k+34.
REQ-020 Latency SHALL be fixed at 34 cycles for every op, including the special cases.
REQ-021 Multiply: the 64-bit product SHALL be formed internally; MUL returns bits [31:0] and the MULH variants return bits [63:32].
REQ-022 Signedness: MULH treats both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU treats both as unsigned.
REQ-023 Divide sign rules: the quotient is negative iff the operand signs differ (signed ops only); the remainder takes the sign of the dividend.
REQ-024 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return op_a.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-026 start while busy=1 SHALL be ignored, with no state or capture change.
REQ-027 start in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.
REQ-028 result and rd_out SHALL hold their values from DONE until the next FIX.
REQ-029 we_out SHALL never assert for rd_out=0.

Reset
REQ-030 rst=1 at any edge, including mid-CALC, SHALL force IDLE and clear the counter, busy, done, we_out, result and rd_out to 0.
REQ-031 An aborted operation SHALL produce no done pulse and no write.
REQ-032 rst SHALL take priority over start.

Structure
REQ-033 Shared package muldiv_pkg SHALL hold the funct3 op enum, the FSM state enum, XLEN, and constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-034 The block SHALL be a single module with no sub-module; the datapath is one 64-bit accumulator/remainder register plus a 32-bit operand register.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 cycles after start; we_out=1 for rd_in=5.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; all with 34-cycle latency.
REQ-039 rst pulsed 10 cycles after start -> busy=0 the next cycle, no done pulse, all outputs 0; a fresh start then completes normally.
REQ-040 A second start at cycle 5 of an operation is ignored and the first operation's result is unchanged; an operation with rd_in=0 gives done=1 and we_out=0.
